// File: rtl/jtag_cmd_regbank_if.sv
// Half-duplex host bridge bundle between the command interpreter (master)
// and debug_bridge_jtag (slave).
interface jtag_cmd_regbank_if;
    logic [31:0] d;    // word to host, valid while wr=1
    logic [31:0] q;    // word from host, valid on ack with wr=0
    logic        req;
    logic        wr;
    logic        ack;

    modport master (output d, req, wr, input q, ack);
    modport slave  (input d, req, wr, output q, ack);
endinterface

// File: rtl/jtag_cmd_regbank.sv
// Host command interpreter: decodes 32-bit host words into control registers,
// one-cycle strobes, soft reset and snapshot status report bursts.
module jtag_cmd_regbank #(
    parameter int          NREGS     = 8,
    parameter int          REG_WIDTH = 24,
    parameter int          NSTATUS   = 4,
    parameter logic [23:0] REG_RESET = 24'h000020
) (
    input  logic                         clk,
    input  logic                         reset,
    jtag_cmd_regbank_if.master           bridge,
    output logic [NREGS*REG_WIDTH-1:0]   regs_q,
    output logic [NREGS-1:0]             reg_wr_stb,
    output logic [7:0]                   pulse_q,
    output logic                         soft_reset,
    input  logic [NSTATUS*32-1:0]        status_d,
    output logic                         busy
);
    localparam int RIW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int SIW = (NSTATUS > 1) ? $clog2(NSTATUS) : 1;
    localparam logic [8:0]           NREGS_C  = 9'(NREGS);
    localparam logic [6:0]           NSTAT_C  = 7'(NSTATUS);
    localparam logic [REG_WIDTH-1:0] RST_V    = REG_RESET[REG_WIDTH-1:0];

    typedef enum logic {IDLE, SEND} state_t;

    state_t                             state_q, state_d;
    logic [NREGS-1:0][REG_WIDTH-1:0]    bank_q, bank_d;
    logic [NSTATUS-1:0][31:0]           snap_q, snap_d;
    logic [6:0]                         idx_q, idx_d;
    logic                               all_q, all_d;
    logic [SIW-1:0]                     sel_q, sel_d;
    logic [7:0]                         err_q, err_d;
    logic [7:0]                         seq_q, seq_d;
    logic [NREGS-1:0]                   stb_d;
    logic [7:0]                         pulse_d;
    logic                               srst_d;
    logic                               req_q;
    logic                               acc;
    logic [7:0]                         cmd;
    logic [6:0]                         last_idx;
    logic [SIW-1:0]                     widx;
    logic [31:0]                        word;
    logic                               unused_q_bits;

    // An ack only counts while a request is outstanding, so a stuck or
    // back-to-back ack can never stretch a strobe or double-step a burst.
    assign acc      = bridge.ack && req_q;
    assign cmd      = bridge.q[31:24];
    assign last_idx = all_q ? NSTAT_C : 7'd1;
    assign widx     = all_q ? SIW'(idx_q - 7'd1) : sel_q;
    assign word     = (idx_q == 7'd0) ? {8'hA5, 8'(NSTATUS), err_q, seq_q} : snap_q[widx];

    assign bridge.req = req_q;
    assign bridge.wr  = (state_q == SEND);
    assign bridge.d   = (state_q == SEND) ? word : 32'h0;
    assign busy       = (state_q == SEND);
    assign regs_q     = bank_q;
    assign unused_q_bits = ^bridge.q;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        all_d   = all_q;
        sel_d   = sel_q;
        err_d   = err_q;
        seq_d   = seq_q;
        stb_d   = '0;
        pulse_d = '0;
        srst_d  = 1'b0;
        unique case (state_q)
            IDLE: if (acc) begin
                if ({1'b0, cmd} < NREGS_C) begin
                    bank_d[cmd[RIW-1:0]] = bridge.q[REG_WIDTH-1:0];
                    stb_d[cmd[RIW-1:0]]  = 1'b1;
                end else if (cmd[7:6] == 2'b10 && {1'b0, cmd[5:0]} < NSTAT_C) begin
                    snap_d  = status_d;
                    sel_d   = cmd[SIW-1:0];
                    all_d   = 1'b0;
                    idx_d   = 7'd0;
                    state_d = SEND;
                end else if (cmd[7:3] == 5'b11110) begin
                    pulse_d[cmd[2:0]] = 1'b1;
                end else if (cmd == 8'hFE) begin
                    snap_d  = status_d;
                    all_d   = 1'b1;
                    idx_d   = 7'd0;
                    state_d = SEND;
                end else if (cmd == 8'hFF) begin
                    srst_d = 1'b1;
                    bank_d = {NREGS{RST_V}};
                end else if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end
            SEND: if (acc) begin
                if (idx_q == last_idx) begin
                    state_d = IDLE;
                    seq_d   = seq_q + 8'd1;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bank_q     <= {NREGS{RST_V}};
            snap_q     <= '0;
            idx_q      <= '0;
            all_q      <= 1'b0;
            sel_q      <= '0;
            err_q      <= '0;
            seq_q      <= '0;
            req_q      <= 1'b0;
            reg_wr_stb <= '0;
            pulse_q    <= '0;
            soft_reset <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            all_q      <= all_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            seq_q      <= seq_d;
            req_q      <= !bridge.ack;
            reg_wr_stb <= stb_d;
            pulse_q    <= pulse_d;
            soft_reset <= srst_d;
        end
    end
endmodule

// File: tb/tb_jtag_cmd_regbank.sv
// Scoreboard bench: stimulus pushes expected burst words and strobe events,
// negedge monitors pop and compare whenever the DUT presents them.
module tb_jtag_cmd_regbank;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jtag_cmd_regbank_if bus();
    logic [191:0] regs_q;
    logic [7:0]   reg_wr_stb;
    logic [7:0]   pulse_q;
    logic         soft_reset;
    logic         busy;
    logic [127:0] status_d;

    jtag_cmd_regbank dut (
        .clk(clk), .reset(reset), .bridge(bus),
        .regs_q(regs_q), .reg_wr_stb(reg_wr_stb), .pulse_q(pulse_q),
        .soft_reset(soft_reset), .status_d(status_d), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_words[$];
    logic [31:0] exp_stb[$];
    logic [23:0] mreg[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stbv(input logic [7:0] s, input logic [7:0] p, input logic r);
        return {15'b0, s, p, r};
    endfunction

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_reg%0d", tag, i), 32'(regs_q[i*24 +: 24]), 32'(mreg[i]));
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) mreg[i] = 24'h000020;
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic wait_rdy(input logic w);
        int n = 0;
        while (!(bus.req === 1'b1 && bus.wr === w) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL wait_rdy: timeout waiting for req with wr=%0b", w);
        end
    endtask

    task automatic host_send(input logic [31:0] w);
        wait_rdy(1'b0);
        bus.q = w; bus.ack = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0; bus.q = 32'h0;
    endtask

    task automatic host_recv(input int n);
        for (int k = 0; k < n; k++) begin
            wait_rdy(1'b1);
            bus.ack = 1'b1;
            @(posedge clk); #1;
            bus.ack = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (bus.ack === 1'b1 && bus.wr === 1'b1) begin
            if (exp_words.size() == 0) begin
                checks++; errors++;
                $display("FAIL burst_word: got %08h expected none", bus.d);
            end else chk("burst_word", bus.d, exp_words.pop_front());
        end
        if (!reset && (|reg_wr_stb || |pulse_q || soft_reset)) begin
            if (exp_stb.size() == 0) begin
                checks++; errors++;
                $display("FAIL strobe: got %08h expected none", stbv(reg_wr_stb, pulse_q, soft_reset));
            end else chk("strobe", stbv(reg_wr_stb, pulse_q, soft_reset), exp_stb.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.q = 32'h0; bus.ack = 1'b0;
        status_d = {32'h4, 32'h3, 32'h2, 32'h1};
        reset_model();

        // 1: reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) chk("req_in_reset", 32'(bus.req), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("req_after_reset", 32'(bus.req), 32'd1);
        chk("wr_after_reset", 32'(bus.wr), 32'd0);
        chk("busy_after_reset", 32'(busy), 32'd0);
        chk("d_after_reset", bus.d, 32'h0);
        chk_regs("reset");

        // 2: register write
        exp_stb.push_back(stbv(8'h04, 8'h00, 1'b0));
        host_send(32'h02123456);
        mreg[2] = 24'h123456;
        @(negedge clk) chk_regs("t2");

        // 3: full snapshot burst, status changes after accept
        exp_words.push_back(32'hA5040000);
        exp_words.push_back(32'h00000001);
        exp_words.push_back(32'h00000002);
        exp_words.push_back(32'h00000003);
        exp_words.push_back(32'h00000004);
        host_send(32'hFE000000);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_wr", 32'(bus.wr), 32'd1);
        status_d = {32'h44, 32'h33, 32'h22, 32'h11};
        host_recv(5);
        @(negedge clk);
        chk("t3_busy_end", 32'(busy), 32'd0);
        chk("t3_wr_end", 32'(bus.wr), 32'd0);

        // 4: bad register index then single status read
        host_send(32'h09000000);
        @(negedge clk) chk_regs("t4");
        exp_words.push_back(32'hA5040101);
        exp_words.push_back(32'h00000022);
        host_send(32'h81000000);
        status_d = {4{32'hFFFFFFFF}};
        host_recv(2);

        // 5: pulse, write, soft reset
        exp_stb.push_back(stbv(8'h00, 8'h08, 1'b0));
        host_send(32'hF3000000);
        exp_stb.push_back(stbv(8'h20, 8'h00, 1'b0));
        host_send(32'h05ABCDEF);
        mreg[5] = 24'hABCDEF;
        @(negedge clk) chk("t5_reg5", 32'(regs_q[5*24 +: 24]), 32'h00ABCDEF);
        exp_stb.push_back(stbv(8'h00, 8'h00, 1'b1));
        host_send(32'hFF000000);
        reset_model();
        @(negedge clk) chk_regs("t5_srst");

        // Stuck ack for two cycles yields a single strobe
        exp_stb.push_back(stbv(8'h08, 8'h00, 1'b0));
        wait_rdy(1'b0);
        bus.q = 32'h03000011; bus.ack = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.ack = 1'b0; bus.q = 32'h0;
        mreg[3] = 24'h000011;
        @(negedge clk) chk("b2b_reg3", 32'(regs_q[3*24 +: 24]), 32'h00000011);

        // 6: reset mid-burst, ack during reset discarded
        status_d = {32'h44, 32'h33, 32'h22, 32'h11};
        exp_words.push_back(32'hA5040102);
        exp_words.push_back(32'h00000011);
        host_send(32'hFE000000);
        host_recv(2);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_wr", 32'(bus.wr), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_d", bus.d, 32'h0);
        bus.q = 32'h02000077; bus.ack = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0; bus.q = 32'h0;
        reset = 1'b0;
        reset_model();
        @(negedge clk) chk_regs("t6_rst");
        exp_words.push_back(32'hA5040000);
        exp_words.push_back(32'h00000011);
        host_send(32'h80000000);
        host_recv(2);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("words_left", 32'(exp_words.size()), 32'd0);
        chk("strobes_left", 32'(exp_stb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
